// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT frame scheduler and its tag FIFO.
package fft_pkg;

    localparam int unsigned SizeDef = 1024;
    localparam int unsigned RnDef   = 14;
    localparam int unsigned TagChW  = 8;

    typedef struct packed {
        logic [RnDef-1:0] re;
        logic [RnDef-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic [TagChW-1:0] ch;
        logic              vld;
    } tag_t;

    localparam int unsigned TagW = $bits(tag_t);

    typedef enum logic {StIdle, StLoad} state_t;

endpackage

// File: rtl/fft_tag_fifo.sv
// Two-entry tag FIFO linking each FFT load window to its output frame.
module fft_tag_fifo
    import fft_pkg::*;
(
    input  logic            clk,
    input  logic            n_reset,
    input  logic            push,
    input  logic            pop,
    input  logic [TagW-1:0] wdata,
    output logic [TagW-1:0] head,
    output logic            full,
    output logic            empty
);

    logic [TagW-1:0] mem_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      cnt_q;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt_q == 2'd0);
    assign full    = (cnt_q == 2'd2);
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 2'd1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/fft_sched.sv
// Round-robin frame scheduler sharing one free-running FFT core between CH channels,
// tagging each load window so results come back labelled with channel and bin.
module fft_sched
    import fft_pkg::*;
#(
    parameter int unsigned SIZE = SizeDef,
    parameter int unsigned RN   = RnDef,
    parameter int unsigned CH   = 2,
    localparam int unsigned AW  = $clog2(SIZE),
    localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [CH-1:0]      ch_rdy,
    output logic [CH-1:0]      ch_take,
    output logic [AW-1:0]      ch_addr,
    input  logic [CH*2*RN-1:0] ch_data,
    input  logic               fft_req,
    output logic [2*RN-1:0]    fft_in,
    input  logic               fft_valid,
    input  logic [2*RN-1:0]    fft_out,
    output logic               out_valid,
    output logic [2*RN-1:0]    out_data,
    output logic [CHW-1:0]     out_ch,
    output logic [AW-1:0]      out_bin,
    output logic               out_last,
    output logic               err
);

    localparam int unsigned   DW       = 2 * RN;
    localparam logic [AW-1:0] LastBeat = AW'(SIZE - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   beat_q, beat_d;
    logic            sel_vld_q, sel_vld_d;
    logic [CHW-1:0]  sel_ch_q, sel_ch_d;
    logic [CHW-1:0]  rr_q, rr_d;
    logic [CH-1:0]   take_q, take_d;
    logic            pick_vld;
    logic [CHW-1:0]  pick_ch;
    logic            push;
    logic            abort;
    tag_t            tag_push;
    tag_t            tag_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fire;
    logic            pop;
    logic [AW-1:0]   cnt_q;
    logic            err_q;
    logic            out_valid_q, out_last_q;
    logic [DW-1:0]   out_data_q;
    logic [CHW-1:0]  out_ch_q;
    logic [AW-1:0]   out_bin_q;
    logic            unused_tag_bits;

    // First ready channel after the last one served.
    always_comb begin
        int unsigned idx;
        pick_vld = 1'b0;
        pick_ch  = '0;
        idx      = 0;
        for (int k = 1; k <= int'(CH); k++) begin
            idx = (32'(rr_q) + 32'(k)) % CH;
            if (!pick_vld && ch_rdy[idx[CHW-1:0]]) begin
                pick_vld = 1'b1;
                pick_ch  = CHW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        sel_vld_d = sel_vld_q;
        sel_ch_d  = sel_ch_q;
        rr_d      = rr_q;
        take_d    = '0;
        push      = 1'b0;
        abort     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fft_req) begin
                    state_d = StLoad;
                    beat_d  = AW'(1);
                end else begin
                    sel_vld_d = pick_vld;
                    sel_ch_d  = pick_ch;
                end
            end
            StLoad: begin
                if (!fft_req) begin
                    abort   = 1'b1;
                    beat_d  = '0;
                    state_d = StIdle;
                end else if (beat_q == LastBeat) begin
                    push    = 1'b1;
                    beat_d  = '0;
                    state_d = StIdle;
                    if (sel_vld_q) begin
                        take_d[sel_ch_q] = 1'b1;
                        rr_d             = sel_ch_q;
                    end
                end else begin
                    beat_d = beat_q + AW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            sel_vld_q <= 1'b0;
            sel_ch_q  <= '0;
            rr_q      <= CHW'(CH - 1);
            take_q    <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            sel_vld_q <= sel_vld_d;
            sel_ch_q  <= sel_ch_d;
            rr_q      <= rr_d;
            take_q    <= take_d;
        end
    end

    // Address runs one ahead of the beat so the 1-cycle read lands on the next req.
    assign ch_addr = fft_req ? beat_q + AW'(1) : beat_q;
    assign fft_in  = (fft_req && sel_vld_q) ? ch_data[32'(sel_ch_q) * DW +: DW] : '0;
    assign ch_take = take_q;

    assign tag_push = '{ch: TagChW'(sel_ch_q), vld: sel_vld_q};

    fft_tag_fifo u_tag_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push),
        .pop     (pop),
        .wdata   (tag_push),
        .head    (tag_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign fire            = fft_valid && !fifo_empty;
    assign pop             = fire && (cnt_q == LastBeat);
    assign unused_tag_bits = ^tag_head.ch;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_bin_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (fire) begin
                out_valid_q <= tag_head.vld;
                out_last_q  <= tag_head.vld && (cnt_q == LastBeat);
                out_data_q  <= fft_out;
                out_ch_q    <= tag_head.ch[CHW-1:0];
                out_bin_q   <= cnt_q;
                cnt_q       <= cnt_q + AW'(1);
            end
            if (abort || (push && fifo_full && !pop) || (fft_valid && fifo_empty)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_bin   = out_bin_q;
    assign err       = err_q;

endmodule
